// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data memory port pair (one read port, one write
//   port). Takes load/store requests from the execute stage over a
//   valid/ready handshake and sequences them into 16-bit word accesses.
//   Byte stores are done as read-modify-write. It keeps at most one request
//   in flight and gives one registered response per request.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_store           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 double, 11 reserved
//   req_signed          sign-extend byte/half loads
//   req_addr            byte address (bit 0 = byte lane)
//   req_wdata           right-aligned store data
//   resp_valid          one-cycle response pulse
//   resp_data           load result (0 for stores and errors)
//   resp_error          misaligned access or reserved size
//   mem_rd_addr/data    read port (data combinational from address)
//   mem_wr_addr/data    write port
//   mem_wr_enable       write strobe, memory writes on next rising edge
module load_store_unit #(
  parameter int MEM_AW = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [MEM_AW:0]   req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_error,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [15:0]       mem_rd_data,
  output logic [MEM_AW-1:0] mem_wr_addr,
  output logic [15:0]       mem_wr_data,
  output logic              mem_wr_enable
);

  // The response cycle has no state of its own. The response is registered
  // on the way back into IDLE, so the unit is ready again in the same cycle
  // that resp_valid is high.
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RMW} state_t;

  state_t state, state_next;

  logic              store_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              lane_q;
  logic              err_q;
  logic [MEM_AW-1:0] w_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q;
  logic              wr_en_q;

  logic              accept;
  logic              req_err;
  logic              done;
  logic [MEM_AW-1:0] req_w;
  logic [MEM_AW-1:0] w_inc;

  function automatic logic [31:0] load_extend(input logic [15:0] word,
                                              input logic is_byte,
                                              input logic lane,
                                              input logic sgn);
    logic [7:0] b;
    b = lane ? word[15:8] : word[7:0];
    if (is_byte)
      return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    return sgn ? {{16{word[15]}}, word} : {16'h0, word};
  endfunction

  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic lane,
                                             input logic [7:0] b);
    return lane ? {b, word[7:0]} : {word[15:8], b};
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_w     = req_addr[MEM_AW:1];
  assign req_err   = (req_size == 2'b11) || ((req_size != 2'b00) && req_addr[0]);
  // Second word wraps modulo the word address space.
  assign w_inc     = w_q + {{(MEM_AW-1){1'b0}}, 1'b1};

  // A strobe that is already presented when reset arrives must not reach memory.
  assign mem_wr_enable = wr_en_q && !reset;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = ACC0;
      ACC0: begin
        if (err_q)                            state_next = IDLE;
        else if (size_q == 2'b10)             state_next = ACC1;
        else if (size_q == 2'b00 && store_q)  state_next = RMW;
        else                                  state_next = IDLE;
      end
      ACC1:    state_next = IDLE;
      RMW:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state != IDLE) && (state_next == IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture and low-half holding register: data only, no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      store_q  <= req_store;
      size_q   <= req_size;
      signed_q <= req_signed;
      lane_q   <= req_addr[0];
      err_q    <= req_err;
      w_q      <= req_w;
      wdata_q  <= req_wdata;
    end
    if (state == ACC0) lo_q <= mem_rd_data;
  end

  // Memory port and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q     <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_error  <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      resp_valid <= done;
      resp_data  <= '0;
      resp_error <= 1'b0;
      case (state)
        IDLE: begin
          // The address is set up on acceptance so the first access in ACC0
          // sees it directly; erroring requests touch neither port.
          if (accept && !req_err) begin
            if (!req_store || req_size == 2'b00) mem_rd_addr <= req_w;
            if (req_store && req_size != 2'b00) begin
              wr_en_q     <= 1'b1;
              mem_wr_addr <= req_w;
              mem_wr_data <= req_wdata[15:0];
            end
          end
        end
        ACC0: begin
          resp_error <= err_q;
          if (!err_q) begin
            if (!store_q) begin
              if (size_q == 2'b10) mem_rd_addr <= w_inc;
              else resp_data <= load_extend(mem_rd_data, size_q == 2'b00, lane_q, signed_q);
            end else if (size_q == 2'b10) begin
              wr_en_q     <= 1'b1;
              mem_wr_addr <= w_inc;
              mem_wr_data <= wdata_q[31:16];
            end else if (size_q == 2'b00) begin
              wr_en_q     <= 1'b1;
              mem_wr_addr <= w_q;
              mem_wr_data <= merge_byte(mem_rd_data, lane_q, wdata_q[7:0]);
            end
          end
        end
        ACC1: begin
          if (!store_q) resp_data <= {mem_rd_data, lo_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory port pair: one read port and one write port.
- Accepts load/store requests from the execute stage over a valid/ready handshake.
- Sequences them into 16-bit word accesses: byte, half-word (16) and double-word (32) sizes, with read-modify-write for byte stores.
- Returns one registered response per request; at most one request is in flight at a time.

Parameters:
- MEM_AW, 20, word-address width of the data memory; the byte address is MEM_AW+1 bits wide.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half (16), 10 double (32), 11 reserved.
- req_signed  in  1  sign-extend loads (byte and half only).
- req_addr  in  MEM_AW+1  byte address; bit 0 selects the byte lane.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_error  out  1  request rejected (misaligned or reserved size).
- mem_rd_addr  out  MEM_AW  data memory read word address.
- mem_rd_data  in  16  data memory read data; combinational from mem_rd_addr, same cycle.
- mem_wr_addr  out  MEM_AW  data memory write word address.
- mem_wr_data  out  16  data memory write data.
- mem_wr_enable  out  1  write strobe; memory writes on the next rising clock.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; req_ready=1; resp_valid=0, resp_data=0, resp_error=0; mem_wr_enable=0; mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0. A reset asserted mid-operation aborts the request:
  - no further memory write is issued;
  - no response is issued;
  - a write strobe already presented in the reset cycle is suppressed.
- req_ready=1 only in IDLE. Handshake = req_valid & req_ready at a rising edge (cycle N). The request is registered and word address W = req_addr[MEM_AW:1].
- States:
  - IDLE: accept request.
  - ACC0: first access at W.
  - ACC1: second access at W+1.
  - RMW: byte-store write-back.
  - RESP: response cycle. resp_valid=1, and the FSM is back in IDLE in this same cycle, so req_ready=1 and back-to-back acceptance is allowed.
- Error check in ACC0: the request is an error if any of the following holds:
  - req_size=11;
  - half/double access with addr[0]=1.

  On error: no read or write, resp_error=1, resp_data=0, latency identical to a half access.
- Half load: ACC0 (N+1) drives mem_rd_addr=W and captures mem_rd_data. Response at N+2, data zero- or sign-extended from 16 bits.
- Double load: ACC0 reads W into the low half. ACC1 (N+2) reads W+1 into the high half. Response at N+3.
- Byte load: ACC0 reads W and selects the lane: addr[0]=0 → [7:0], addr[0]=1 → [15:8]. Extension is per req_signed. Response at N+2.
- Half store: ACC0 asserts mem_wr_enable with mem_wr_addr=W, mem_wr_data=wdata[15:0]. Response at N+2.
- Double store:
  - ACC0 writes wdata[15:0] to W.
  - ACC1 writes wdata[31:16] to W+1.
  - Response at N+3.
- Byte store:
  - ACC0 reads W and captures the word.
  - RMW (N+2) writes the merged word to W: only the addressed lane is replaced by wdata[7:0], the other lane is kept.
  - Response at N+3.
- Address wrap: W+1 is computed modulo 2^MEM_AW; W=0xFFFFF gives second word 0x00000. No error.
- mem_wr_enable is high for exactly one cycle per written word and never in IDLE.
- mem_rd_addr holds the last driven value when not reading.
- resp_data and resp_error are valid only while resp_valid=1 and are cleared to 0 in the following cycle.
- Inputs are sampled only at acceptance. Changes to req_* while busy are ignored.

Test Plan:
- Memory word 0x00010=0xBEEF; half load addr=0x00020 (W=0x10), unsigned → resp_valid at N+2, resp_data=0x0000BEEF, resp_error=0. The same load with signed → 0xFFFFBEEF.
- Byte load addr=0x00021, signed, word=0x80FF → resp_data=0xFFFFFF80. Addr 0x00020, unsigned → 0x000000FF.
- Double store addr=0x1FFFFE (W=0xFFFFF), wdata=0x12345678:
  - writes 0x5678 @0xFFFFF at N+1 and 0x1234 @0x00000 at N+2;
  - resp at N+3;
  - a double load at the same address returns 0x12345678.
- Byte store addr=0x00041, wdata=0xAB, word 0x20 initially 0x1122:
  - read at N+1;
  - write 0xAB22 at N+2;
  - resp at N+3, resp_data=0.
- Misaligned half load addr=0x00031 → no memory write strobe, resp at N+2 with resp_error=1, resp_data=0. req_size=11 gives the same result.
- Reset asserted during ACC1 of a double store → no write to W+1 occurs, no resp_valid, req_ready=1 the cycle after reset. A subsequent half load completes normally at N+2.
